// File: rtl/piano_pkg.sv
// Shared types and constants for the piano note scheduler: note and FSM
// state encodings, the tone half-period ROM and small helper functions.
package piano_pkg;

   localparam int TONE_DIV_W = 17;

   typedef enum logic [2:0] {
      NOTE_C    = 3'd0,
      NOTE_D    = 3'd1,
      NOTE_E    = 3'd2,
      NOTE_F    = 3'd3,
      NOTE_G    = 3'd4,
      NOTE_A    = 3'd5,
      NOTE_B    = 3'd6,
      NOTE_NONE = 3'd7
   } note_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      PLAY    = 2'd2,
      RELEASE = 2'd3
   } sched_state_t;

   // Half-period divisors for a 50 MHz clock.
   localparam logic [TONE_DIV_W-1:0] TONE_DIV_C = 17'd95556;
   localparam logic [TONE_DIV_W-1:0] TONE_DIV_D = 17'd85131;
   localparam logic [TONE_DIV_W-1:0] TONE_DIV_E = 17'd75843;
   localparam logic [TONE_DIV_W-1:0] TONE_DIV_F = 17'd71586;
   localparam logic [TONE_DIV_W-1:0] TONE_DIV_G = 17'd63776;
   localparam logic [TONE_DIV_W-1:0] TONE_DIV_A = 17'd56818;
   localparam logic [TONE_DIV_W-1:0] TONE_DIV_B = 17'd50619;

   // ROM lookup; NOTE_NONE maps to a silent zero divisor.
   function automatic logic [TONE_DIV_W-1:0] tone_div_rom(input note_t n);
      logic [TONE_DIV_W-1:0] d;
      case (n)
         NOTE_C:  d = TONE_DIV_C;
         NOTE_D:  d = TONE_DIV_D;
         NOTE_E:  d = TONE_DIV_E;
         NOTE_F:  d = TONE_DIV_F;
         NOTE_G:  d = TONE_DIV_G;
         NOTE_A:  d = TONE_DIV_A;
         NOTE_B:  d = TONE_DIV_B;
         default: d = '0;
      endcase
      return d;
   endfunction

   // Highest set bit of a key vector as a note, NOTE_NONE when empty.
   function automatic note_t highest_note(input logic [6:0] keys);
      note_t r;
      r = NOTE_NONE;
      for (int i = 0; i < 7; i++) begin
         if (keys[i]) r = note_t'(3'(i));
      end
      return r;
   endfunction

endpackage

// File: rtl/note_scheduler_debouncer.sv
// One-bit key debouncer: two-flop synchronizer followed by a stability
// counter. The debounced level flips only after the synchronized input has
// disagreed with it for DEBOUNCE_CYCLES consecutive cycles; any bounce back
// restarts the count. Input-to-output latency is 2 + DEBOUNCE_CYCLES.
module key_debouncer #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             meta;
   logic             synced;
   logic [CNT_W-1:0] cnt;

   // Synchronize the raw key and count consecutive cycles of disagreement.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta   <= 1'b0;
         synced <= 1'b0;
         cnt    <= '0;
         level  <= 1'b0;
      end else begin
         meta   <= raw;
         synced <= meta;
         if (synced != level) begin
            if (cnt == CNT_LAST) begin
               level <= synced;
               cnt   <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/note_scheduler.sv
// Monophonic note scheduler: debounces seven note keys, picks one note
// (newest press wins, fall back to the highest held key) and drives a shared
// tone generator through a load/ack handshake, keeping the tone enabled for
// a release tail after the last key goes up.
// Optional feature macro: NOTE_SCHED_OCTAVE_EN adds an octave_up input that
// halves the divisor (one octave higher).
// Handshake: tone_load is high exactly while the FSM is in LOAD; tone_div and
// note_idx are stable while it is high unless the selection itself changes.
// The generator acknowledges by raising tone_ack for at least one cycle;
// tone_ack is ignored in every other state. tone_load falls on the edge that
// samples tone_ack, or asynchronously on reset (treated as an abort).
module note_scheduler
   import piano_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int RELEASE_CYCLES  = 2_500_000,
   parameter int DIV_W           = 17
) (
   input  logic             CLOCK_50,
   input  logic             reset_n,
   input  logic [6:0]       note_in,
`ifdef NOTE_SCHED_OCTAVE_EN
   input  logic             octave_up,
`endif
   input  logic             tone_ack,
   output logic             tone_load,
   output logic [DIV_W-1:0] tone_div,
   output logic             tone_en,
   output logic [2:0]       note_idx,
   output logic [6:0]       keys_db,
   output sched_state_t     state
);

   localparam int RCNT_W = $clog2(RELEASE_CYCLES + 1);
   localparam logic [RCNT_W-1:0] REL_LAST = RCNT_W'(RELEASE_CYCLES - 1);

   sched_state_t          next_state;
   logic [6:0]            keys_prev;
   logic [6:0]            rise;
   logic [7:0]            keys_ext;
   logic                  held;
   note_t                 sel_q;
   note_t                 sel_cur;
   logic [TONE_DIV_W-1:0] rom_val;
   logic [DIV_W-1:0]      div_cur;
   logic                  changed;
   logic [RCNT_W-1:0]     rel_cnt;
   logic                  take_sel;
   logic                  set_en;
   logic                  go_idle;
   logic                  start_tail;
   logic                  tail_step;

   genvar gi;
   generate
      for (gi = 0; gi < 7; gi++) begin : g_db
         key_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
         ) u_db (
            .clk  (CLOCK_50),
            .rst_n(reset_n),
            .raw  (note_in[gi]),
            .level(keys_db[gi])
         );
      end
   endgenerate

`ifdef NOTE_SCHED_OCTAVE_EN
   logic oct_meta;
   logic oct_sync;

   // Octave switch is only synchronized; it is a level, not a bouncing key.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         oct_meta <= 1'b0;
         oct_sync <= 1'b0;
      end else begin
         oct_meta <= octave_up;
         oct_sync <= oct_meta;
      end
   end
`endif

   // Arbitration: newest rising key wins (highest index on ties); when the
   // selected key drops, fall back to the highest key still held.
   always_comb begin
      rise     = keys_db & ~keys_prev;
      held     = |keys_db;
      keys_ext = {1'b0, keys_db};
      sel_cur  = sel_q;
      if (rise != 7'd0) begin
         sel_cur = highest_note(rise);
      end else if (!held) begin
         sel_cur = NOTE_NONE;
      end else if (sel_q == NOTE_NONE || !keys_ext[sel_q]) begin
         sel_cur = highest_note(keys_db);
      end
   end

   // Divisor for the current selection, optionally shifted up an octave.
   always_comb begin
      rom_val = tone_div_rom(sel_cur);
`ifdef NOTE_SCHED_OCTAVE_EN
      div_cur = oct_sync ? DIV_W'(rom_val >> 1) : DIV_W'(rom_val);
`else
      div_cur = DIV_W'(rom_val);
`endif
      changed = held && ((sel_cur != note_idx) || (div_cur != tone_div));
   end

   // FSM state register.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= next_state;
   end

   // FSM next-state and datapath control strobes.
   always_comb begin
      next_state = state;
      take_sel   = 1'b0;
      set_en     = 1'b0;
      go_idle    = 1'b0;
      start_tail = 1'b0;
      tail_step  = 1'b0;
      case (state)
         IDLE: begin
            if (held) begin
               next_state = LOAD;
               take_sel   = 1'b1;
            end
         end
         LOAD: begin
            // A new selection supersedes a pending acknowledge.
            if (changed) begin
               take_sel = 1'b1;
            end else if (tone_ack) begin
               next_state = PLAY;
               set_en     = 1'b1;
            end
         end
         PLAY: begin
            if (!held) begin
               next_state = RELEASE;
               start_tail = 1'b1;
            end else if (changed) begin
               next_state = LOAD;
               take_sel   = 1'b1;
            end
         end
         RELEASE: begin
            // A fresh press beats a tail expiry in the same cycle.
            if (held) begin
               next_state = LOAD;
               take_sel   = 1'b1;
            end else if (rel_cnt == REL_LAST) begin
               next_state = IDLE;
               go_idle    = 1'b1;
            end else begin
               tail_step = 1'b1;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   assign tone_load = (state == LOAD);

   // Selection tracking, registered divisor/note outputs and release counter.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         keys_prev <= '0;
         sel_q     <= NOTE_NONE;
         note_idx  <= 3'd7;
         tone_div  <= '0;
         tone_en   <= 1'b0;
         rel_cnt   <= '0;
      end else begin
         keys_prev <= keys_db;
         sel_q     <= sel_cur;
         if (take_sel) begin
            note_idx <= sel_cur;
            tone_div <= div_cur;
         end
         if (set_en) tone_en <= 1'b1;
         if (go_idle) begin
            tone_en  <= 1'b0;
            note_idx <= 3'd7;
         end
         if (start_tail)     rel_cnt <= '0;
         else if (tail_step) rel_cnt <= rel_cnt + RCNT_W'(1);
      end
   end

endmodule
